// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end feeding the IF/ID register.
// Owns the fetch PC, issues one word request at a time to a fixed one-cycle
// latency instruction memory, buffers returned words with their PCs in a
// DEPTH-entry FIFO and hands them to decode. A redirect from EX flushes the
// queue and restarts fetch at the target.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   When defined, a response arriving while the queue is empty is presented
//   to decode in the same cycle and, if accepted, never written to storage.
//   When undefined, decode only ever sees queue storage (2-cycle minimum
//   request-to-instr_valid latency).
//
// Handshake: a decode transfer happens in a cycle where instr_valid and
// instr_ready are both high and redirect_valid is low; instr_valid never
// depends on instr_ready, and instr_ready while instr_valid is low is ignored.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rsp_pc;
    logic             inflight;
    logic [CW-1:0]    count;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];

    logic             empty;
    logic             rsp_ok;
    logic             bypass_take;
    logic             push;
    logic             pop;
    logic [CW:0]      occupancy;

    assign empty     = (count == '0);
    // A response only counts when we actually have a request outstanding and
    // no redirect is discarding it this cycle.
    assign rsp_ok    = imem_rsp_valid & inflight & ~redirect_valid;
    // Slots already promised: stored entries plus the word still in flight.
    // Pops this cycle are deliberately not credited.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

    assign imem_req_valid = rst & ~redirect_valid & (occupancy < DEPTH_V);
    assign imem_req_addr  = pc;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_take = empty & rsp_ok & instr_ready;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = rsp_ok & ~bypass_take;
    assign pop  = ~empty & instr_ready & ~redirect_valid;

    // Decode-facing head: queue storage first, optionally the live response.
    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (!empty) begin
            instr_valid = 1'b1;
            instr       = data_mem[rd_ptr];
            instr_pc    = pc_mem[rd_ptr];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (rsp_ok) begin
            instr_valid = 1'b1;
            instr       = imem_rsp_data;
            instr_pc    = rsp_pc;
        end
`endif
    end

    // Fetch PC, in-flight tracking, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            rsp_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= imem_req_valid;
            if (imem_req_valid) begin
                rsp_pc <= pc;
            end
            if (redirect_valid) begin
                // Redirect wins over any push/pop this cycle.
                pc     <= redirect_pc;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (imem_req_valid) begin
                    pc <= pc + WIDTH'(4);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is a memory protocol error; the
    // datapath already ignores it, this flags it in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(imem_rsp_valid && !inflight));
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
// The memory returns addr ^ 32'hA5A5_0000 one cycle after each request.
// A queue-of-PCs reference model predicts every output each cycle; a vector
// table and hand-written sequences add explicit checks for the corner cases.
module tb_fetch_queue;

    localparam int          WIDTH    = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             imem_req_valid;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             instr_valid;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             instr_ready;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int               n_checks;
    int               n_errors;
    logic [WIDTH-1:0] exp_q[$];      // PCs of words the queue should hold
    logic             m_inflight;    // a request is outstanding
    logic [31:0]      m_pc;          // next fetch address
    logic [31:0]      m_rsp_pc;      // address of the outstanding request
    logic             mem_v;         // memory response for next cycle
    logic [31:0]      mem_d;
    logic             s_req_v, s_iv; // outputs sampled in the last step
    logic [31:0]      s_addr, s_instr, s_ipc;

    typedef struct {
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_inflight = 1'b0;
        m_pc       = RESET_PC;
        m_rsp_pc   = '0;
        mem_v      = 1'b0;
        mem_d      = '0;
    endtask

    // Assert reset (asynchronously, from wherever we are), check the outputs
    // respond at once, hold for some edges, release just after an edge.
    task automatic do_reset(input int cycles);
        rst            = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        model_reset();
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, compare with
    // the model, then advance the model across the rising edge.
    task automatic step(input logic ready, input logic redir, input logic [31:0] rpc);
        logic        e_req;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic        consumed;
        instr_ready    = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = mem_v;
        imem_rsp_data  = mem_d;
        @(negedge clk);
        s_req_v = imem_req_valid;
        s_addr  = imem_req_addr;
        s_iv    = instr_valid;
        s_instr = instr;
        s_ipc   = instr_pc;

        e_req = !redir && ((exp_q.size() + int'(m_inflight)) < DEPTH);
        e_iv  = 1'b0;
        e_ipc = '0;
        if (exp_q.size() > 0) begin
            e_iv  = 1'b1;
            e_ipc = exp_q[0];
        end else if (BYP && m_inflight && !redir) begin
            e_iv  = 1'b1;
            e_ipc = m_rsp_pc;
        end
        check("req_valid", s_req_v, e_req);
        check("req_addr", s_addr, m_pc);
        check("instr_valid", s_iv, e_iv);
        check("instr_pc", s_ipc, e_ipc);
        check("instr", s_instr, e_iv ? (e_ipc ^ KEY) : 32'h0);

        mem_v = s_req_v;
        mem_d = s_addr ^ KEY;

        if (redir) begin
            exp_q.delete();
            m_pc       = rpc;
            m_inflight = 1'b0;
        end else begin
            consumed = e_iv && ready;
            if (exp_q.size() > 0) begin
                if (consumed) void'(exp_q.pop_front());
                if (m_inflight) exp_q.push_back(m_rsp_pc);
            end else if (m_inflight && !consumed) begin
                exp_q.push_back(m_rsp_pc);
            end
            if (e_req) begin
                m_rsp_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
            m_inflight = e_req;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          first;
        logic [31:0] want;
        bit          seen;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        model_reset();
        #2;

        // Startup with decode always ready: first valid in cycle 2 (1 with bypass).
        do_reset(3);
        first = -1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, '0);
            if (s_iv && first < 0) begin
                first = i;
                check("first_pc", s_ipc, RESET_PC);
            end
        end
        check("first_valid_cycle", first, BYP ? 1 : 2);

        // Fill with decode stalled, then drain: vector table.
        vecs[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'd4,  BYP,  32'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
        vecs[4]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[5]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[6]  = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[7]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd4};
        vecs[8]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
        vecs[9]  = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
        vecs[10] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
        vecs[11] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd20};
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].ready, 1'b0, '0);
            check($sformatf("vec%0d_req_valid", i), s_req_v, vecs[i].e_req);
            check($sformatf("vec%0d_req_addr", i), s_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_instr_valid", i), s_iv, vecs[i].e_iv);
            check($sformatf("vec%0d_instr_pc", i), s_ipc, vecs[i].e_ipc);
            check($sformatf("vec%0d_instr", i), s_instr,
                  vecs[i].e_iv ? (vecs[i].e_ipc ^ KEY) : 32'h0);
        end

        // Redirect with 3 entries queued and a response in flight.
        do_reset(2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b0, '0);
        check("redir_next_valid", s_iv, 0);
        check("redir_next_req", s_req_v, 1);
        check("redir_next_addr", s_addr, 32'h0000_0100);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step(1'b1, 1'b0, '0);
            if (s_iv) begin
                seen = 1'b1;
                check("redir_first_pc", s_ipc, 32'h0000_0100);
            end
        end
        if (!seen) check("redir_first_valid_timeout", 0, 1);

        // Redirect in the same cycle as a handshake: no duplicate, no gap.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0200);
        check("redir_pop_head_valid", s_iv, 1);
        want = 32'h0000_0200;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, '0);
            if (s_iv) begin
                check("redir_pop_seq", s_ipc, want);
                want = want + 32'd4;
            end
        end
        check("redir_pop_progress", (want > 32'h0000_0210) ? 1 : 0, 1);

        // Asynchronous reset mid-stream with 2 entries queued.
        do_reset(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        check("pre_reset_valid", s_iv, 1);
        #2;
        do_reset(2);
        step(1'b1, 1'b0, '0);
        check("post_reset_addr", s_addr, RESET_PC);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, '0);
        check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, '0);
        check("wrap_addr_zero", s_addr, 32'h0000_0000);
        check("wrap_valid_after_req", s_iv, BYP);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

        // Randomized traffic against the reference model.
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            logic        rdy;
            logic        rd;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            step(rdy, rd, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
